// File: rtl/clz_share_ctrl.sv
// clz_share_ctrl: shares one combinational leading-zero counter between two
// requesters. Grants round-robin, issues the latched operand to the counter
// for one cycle, registers the count and returns it with a one-cycle valid.
// CLO is done by inverting the operand before it reaches the counter.
//
// Optional feature macro: CLZ_SHARE_CTRL_PIPE_EN
//   defined   - RESP also arbitrates, so back-to-back ops take 2 cycles each.
//   undefined - RESP always returns to IDLE, 3 cycles per op.
module clz_share_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RES_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0
  input  logic              in_req0,
  input  logic              in_op0,
  input  logic [DATA_W-1:0] in_data0,
  output logic              out_ack0,
  output logic              out_valid0,
  output logic [RES_W-1:0]  out_res0,
  // requester 1
  input  logic              in_req1,
  input  logic              in_op1,
  input  logic [DATA_W-1:0] in_data1,
  output logic              out_ack1,
  output logic              out_valid1,
  output logic [RES_W-1:0]  out_res1,
  // shared counter
  output logic [DATA_W-1:0] out_cnt_data,
  output logic              out_cnt_ena,
  input  logic [RES_W-1:0]  in_cnt_res,
  // status
  output logic              out_busy
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              rr_last_q, rr_last_d;  // index of the last granted requester
  logic              gnt_q, gnt_d;          // index of the requester being served
  logic [DATA_W-1:0] opnd_q, opnd_d;        // operand with CLO inversion already applied
  logic [RES_W-1:0]  res0_q, res0_d;
  logic [RES_W-1:0]  res1_q, res1_d;

  logic              any_req;
  logic              arb_gnt;
  logic [DATA_W-1:0] sel_opnd;

  // Round-robin arbitration and operand selection for a grant this cycle
  always_comb begin
    any_req  = in_req0 | in_req1;
    // On a tie the requester that was not granted last wins; otherwise the lone requester wins
    arb_gnt  = (in_req0 && in_req1) ? ~rr_last_q : in_req1;
    sel_opnd = arb_gnt ? (in_data1 ^ {DATA_W{in_op1}})
                       : (in_data0 ^ {DATA_W{in_op0}});
  end

  // Next-state logic: sequencing, grant capture and result capture
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    gnt_d     = gnt_q;
    opnd_d    = opnd_q;
    res0_d    = res0_q;
    res1_d    = res1_q;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d   = StIssue;
          gnt_d     = arb_gnt;
          rr_last_d = arb_gnt;
          opnd_d    = sel_opnd;
        end
      end

      StIssue: begin
        // The counter result is only meaningful while we drive it
        if (gnt_q) begin
          res1_d = in_cnt_res;
        end else begin
          res0_d = in_cnt_res;
        end
        state_d = StResp;
      end

      StResp: begin
        state_d = StIdle;
`ifdef CLZ_SHARE_CTRL_PIPE_EN
        if (any_req) begin
          state_d   = StIssue;
          gnt_d     = arb_gnt;
          rr_last_d = arb_gnt;
          opnd_d    = sel_opnd;
        end
`endif
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rr_last_q <= 1'b1;
      gnt_q     <= 1'b0;
      opnd_q    <= '0;
      res0_q    <= '0;
      res1_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      gnt_q     <= gnt_d;
      opnd_q    <= opnd_d;
      res0_q    <= res0_d;
      res1_q    <= res1_d;
    end
  end

  // Output decode: ack and counter drive in ISSUE, valid in RESP
  always_comb begin
    out_ack0     = 1'b0;
    out_ack1     = 1'b0;
    out_valid0   = 1'b0;
    out_valid1   = 1'b0;
    out_cnt_ena  = 1'b0;
    out_cnt_data = '0;

    unique case (state_q)
      StIssue: begin
        out_cnt_ena  = 1'b1;
        out_cnt_data = opnd_q;
        out_ack0     = ~gnt_q;
        out_ack1     = gnt_q;
      end
      StResp: begin
        out_valid0 = ~gnt_q;
        out_valid1 = gnt_q;
      end
      default: begin
      end
    endcase
  end

  assign out_res0 = res0_q;
  assign out_res1 = res1_q;
  assign out_busy = (state_q != StIdle);

  // Invariants: only one requester is ever acked or answered at a time
  a_ack_excl: assert property (@(posedge clk) !(out_ack0 && out_ack1));
  a_valid_excl: assert property (@(posedge clk) !(out_valid0 && out_valid1));
  a_ena_only_busy: assert property (@(posedge clk) out_cnt_ena |-> out_busy);

endmodule
